// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: {Bout, Diff} = In1 - In2 - Bin.
module full_subtractor (
  input  logic In1,
  input  logic In2,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  logic w_x;

  assign w_x  = In1 ^ In2;
  assign Diff = w_x ^ Bin;
  assign Bout = (~In1 & In2) | (~w_x & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor: Diff = A - B - Bin over WIDTH cycles with a
// Start/Done handshake. Operands are latched, so inputs may change after Start.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-2:0] r_d_sr;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_brw_next;
  logic             w_last;
  logic [WIDTH-1:0] w_diff_final;

  full_subtractor u_cell (
    .In1  (r_a_sr[0]),
    .In2  (r_b_sr[0]),
    .Bin  (r_brw),
    .Diff (w_d),
    .Bout (w_brw_next)
  );

  assign w_last       = (r_cnt == CNT_W'(WIDTH - 1));
  // Partial result holds only the WIDTH-1 bits already produced; the current
  // bit completes it, so the full word is available on the final edge.
  assign w_diff_final = {w_d, r_d_sr};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (Start) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_d_sr  <= '0;
      r_brw   <= 1'b0;
      r_cnt   <= '0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_a_sr  <= A;
            r_b_sr  <= B;
            r_brw   <= Bin;
            r_cnt   <= '0;
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_d_sr <= w_diff_final[WIDTH-1:1];
          r_brw  <= w_brw_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_diff <= w_diff_final;
            r_bout <= w_brw_next;
            // On the last edge w_d is the result MSB.
            r_ovf  <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy     = (r_state == ST_SHIFT);
  assign Done     = (r_state == ST_DONE);
  assign Diff     = r_diff;
  assign Bout     = r_bout;
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8 and WIDTH=4) and its 1-bit cell.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8, ovf8;
  logic [7:0] diff8;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4, ovf4;
  logic [3:0] diff4;

  logic       fs_in1 = 1'b0, fs_in2 = 1'b0, fs_bin = 1'b0;
  logic       fs_diff, fs_bout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .Clk(clk), .Rst(rst), .Start(start8), .A(a8), .B(b8), .Bin(bin8),
    .Busy(busy8), .Done(done8), .Diff(diff8), .Bout(bout8), .Overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .Clk(clk), .Rst(rst), .Start(start4), .A(a4), .B(b4), .Bin(bin4),
    .Busy(busy4), .Done(done4), .Diff(diff4), .Bout(bout4), .Overflow(ovf4)
  );

  full_subtractor u_fs (
    .In1(fs_in1), .In2(fs_in2), .Bin(fs_bin), .Diff(fs_diff), .Bout(fs_bout)
  );

  // Runs one WIDTH=8 operation; lat is the negedge index (0 = right after the
  // accept edge) at which Done was seen. Operands are scrambled after acceptance.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                        output logic [7:0] d, output logic bo, output logic ov,
                        output int lat, output int nbusy);
    int k;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bin;
    k = 0; nbusy = 0; lat = -1; d = '0; bo = 1'b0; ov = 1'b0;
    while (k <= 40 && lat < 0) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (done8) begin lat = k; d = diff8; bo = bout8; ov = ovf8; end
      k++;
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL op8_timeout a=%h b=%h bin=%0d: no Done within 40 cycles", a, b, bin);
    end
  endtask

  task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                        output logic [3:0] d, output logic bo, output logic ov,
                        output int lat);
    int k;
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; a4 = ~a; b4 = ~b; bin4 = ~bin;
    k = 0; lat = -1; d = '0; bo = 1'b0; ov = 1'b0;
    while (k <= 20 && lat < 0) begin
      @(negedge clk);
      if (done4) begin lat = k; d = diff4; bo = bout4; ov = ovf4; end
      k++;
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL op4_timeout a=%h b=%h bin=%0d: no Done within 20 cycles", a, b, bin);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] d, input logic bo, input logic ov,
                        input logic [7:0] ed, input logic ebo, input logic eov);
    n_checks++;
    if ({d, bo, ov} !== {ed, ebo, eov}) begin
      n_fail++;
      $display("FAIL %s: got diff=%h bout=%0d ovf=%0d, want diff=%h bout=%0d ovf=%0d",
               name, d, bo, ov, ed, ebo, eov);
    end else
      $display("ok   %s: diff=%h bout=%0d ovf=%0d", name, d, bo, ov);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset8: got busy=%0d done=%0d diff=%h bout=%0d ovf=%0d, want all 0",
               busy8, done8, diff8, bout8, ovf8);
    end else $display("ok   reset8");
    n_checks++;
    if ({busy4, done4, diff4, bout4, ovf4} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset4: got busy=%0d done=%0d diff=%h, want all 0", busy4, done4, diff4);
    end else $display("ok   reset4");
    rst = 1'b0;
  endtask

  task automatic test_full_subtractor();
    for (int i = 0; i < 8; i++) begin
      int r;
      logic [2:0] v;
      v = 3'(i);
      fs_in1 = v[2]; fs_in2 = v[1]; fs_bin = v[0];
      #1;
      r = int'(v[2]) - int'(v[1]) - int'(v[0]);
      n_checks++;
      if ({fs_bout, fs_diff} !== {r < 0, r[0]}) begin
        n_fail++;
        $display("FAIL fs_row%0d: got bout=%0d diff=%0d, want bout=%0d diff=%0d",
                 i, fs_bout, fs_diff, r < 0, r[0]);
      end else $display("ok   fs_row%0d: bout=%0d diff=%0d", i, fs_bout, fs_diff);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d; logic bo, ov; int lat, nb;
    do_op8(8'h05, 8'h03, 1'b0, d, bo, ov, lat, nb);
    check8("basic_05_03", d, bo, ov, 8'h02, 1'b0, 1'b0);
    n_checks++;
    if (lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", lat); end
    else $display("ok   basic_latency: %0d", lat);
    n_checks++;
    if (nb !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", nb); end
    else $display("ok   basic_busy_cycles: %0d", nb);
  endtask

  task automatic test_wrap();
    logic [7:0] d; logic bo, ov; int lat, nb;
    do_op8(8'h03, 8'h05, 1'b0, d, bo, ov, lat, nb);
    check8("wrap_03_05", d, bo, ov, 8'hFE, 1'b1, 1'b0);
    do_op8(8'h00, 8'h00, 1'b1, d, bo, ov, lat, nb);
    check8("wrap_00_00_bin", d, bo, ov, 8'hFF, 1'b1, 1'b0);
    do_op8(8'hA5, 8'h24, 1'b1, d, bo, ov, lat, nb);
    check8("plain_A5_24_bin", d, bo, ov, 8'h80, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [7:0] d; logic bo, ov; int lat, nb;
    do_op8(8'h80, 8'h01, 1'b0, d, bo, ov, lat, nb);
    check8("ovf_80_01", d, bo, ov, 8'h7F, 1'b0, 1'b1);
    do_op8(8'h7F, 8'hFF, 1'b0, d, bo, ov, lat, nb);
    check8("ovf_7F_FF", d, bo, ov, 8'h80, 1'b1, 1'b1);
  endtask

  // Previous result is 0x80/1/1; it must hold until the new completion edge.
  task automatic test_output_hold();
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy8, diff8, bout8, ovf8} !== {1'b1, 8'h80, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL hold_mid_op: got busy=%0d diff=%h bout=%0d ovf=%0d, want 1 80 1 1",
               busy8, diff8, bout8, ovf8);
    end else $display("ok   hold_mid_op");
    repeat (4) @(negedge clk);
    n_checks++;
    if ({done8, diff8, bout8, ovf8} !== {1'b1, 8'h0F, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL hold_complete: got done=%0d diff=%h bout=%0d ovf=%0d, want 1 0f 0 0",
               done8, diff8, bout8, ovf8);
    end else $display("ok   hold_complete");
  endtask

  task automatic test_latched_operands();
    logic [7:0] d; logic bo, ov; int lat, nb;
    do_op8(8'h20, 8'h03, 1'b0, d, bo, ov, lat, nb);
    check8("latched_20_03", d, bo, ov, 8'h1D, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int ndone, first, bad;
    ndone = 0; first = -1; bad = 0;
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done8) begin
        ndone++;
        if (first < 0) first = k;
        if (k != 8 + 10 * (ndone - 1)) bad++;
      end
    end
    start8 = 1'b0;
    n_checks++;
    if (ndone !== 4 || bad !== 0) begin
      n_fail++;
      $display("FAIL back_to_back: got %0d Done pulses (first at %0d, %0d misplaced), want 4 every 10 from 8",
               ndone, first, bad);
    end else $display("ok   back_to_back: 4 Done pulses every 10 cycles");
    check8("back_to_back_result", diff8, bout8, ovf8, 8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a8 = 8'h09; b8 = 8'h04; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done8) ndone++;
      start8 = (k == 2 || k == 8);
    end
    start8 = 1'b0;
    n_checks++;
    if (ndone !== 1) begin
      n_fail++;
      $display("FAIL start_ignored: got %0d Done pulses, want 1", ndone);
    end else $display("ok   start_ignored");
    check8("start_ignored_result", diff8, bout8, ovf8, 8'h05, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    int ndone;
    logic [7:0] d; logic bo, ov; int lat, nb;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_mid_op: got busy=%0d done=%0d diff=%h bout=%0d ovf=%0d, want all 0",
               busy8, done8, diff8, bout8, ovf8);
    end else $display("ok   reset_mid_op");
    rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d busy/done cycles after abort, want 0", ndone);
    end else $display("ok   reset_no_done");
    do_op8(8'h10, 8'h01, 1'b0, d, bo, ov, lat, nb);
    check8("after_reset_10_01", d, bo, ov, 8'h0F, 1'b0, 1'b0);
  endtask

  task automatic test_exhaustive4();
    int nbad;
    nbad = 0;
    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          logic [3:0] d, ed, av, bv;
          logic bo, ov, ebo, eov;
          int lat, r;
          av = 4'(ai); bv = 4'(bi);
          do_op4(av, bv, ci[0], d, bo, ov, lat);
          r   = ai - bi - ci;
          ed  = 4'(r);
          ebo = (r < 0);
          eov = (av[3] != bv[3]) && (ed[3] != av[3]);
          n_checks++;
          if ({d, bo, ov} !== {ed, ebo, eov} || lat !== 4) begin
            n_fail++; nbad++;
            $display("FAIL exh4 a=%h b=%h bin=%0d: got diff=%h bout=%0d ovf=%0d lat=%0d, want %h %0d %0d lat=4",
                     av, bv, ci, d, bo, ov, lat, ed, ebo, eov);
          end
        end
    $display("exh4: 512 operations, %0d wrong", nbad);
  endtask

  initial begin
    test_reset();
    test_full_subtractor();
    test_basic();
    test_wrap();
    test_overflow();
    test_output_hold();
    test_latched_operands();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_op();
    test_exhaustive4();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor. Computes Diff = A - B - Bin over WIDTH clock cycles, using one full-subtractor cell and a borrow flip-flop.
- Companion to the combinational full adder: it is the inverse arithmetic direction, sequenced over time.
- Sits in the datapath as an area-cheap ALU subtract unit with a Start/Done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not to be overridden).

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; latched on accepted Start.
- B  input  WIDTH  subtrahend; latched on accepted Start.
- Bin  input  1  borrow-in; latched on accepted Start.
- Busy  output  1  high while in SHIFT.
- Done  output  1  one-cycle pulse; result valid.
- Diff  output  WIDTH  result; held until the next completion.
- Bout  output  1  final borrow-out (unsigned A < B + Bin).
- Overflow  output  1  two's-complement overflow of the result.

Behaviour:
- Clocking: one clock, Clk. Rst is synchronous and active-high and takes priority over all other inputs.
- Reset values:
  - state = IDLE.
  - Busy = 0, Done = 0, Diff = 0, Bout = 0, Overflow = 0.
  - Internal shift registers, borrow flip-flop and counter = 0.
- States:
  - IDLE: wait for Start.
  - SHIFT: process one bit per cycle.
  - DONE: present the result for one cycle.
- IDLE:
  - If Start = 1 at an edge: load a_sr = A, b_sr = B, brw = Bin, cnt = 0, and go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, at each edge:
  - Bit computation: d = a_sr[0] ^ b_sr[0] ^ brw.
  - Borrow update: brw' = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw).
  - Shifts: a_sr and b_sr shift right; d_sr shifts right with d inserted at the MSB.
  - cnt increments.
  - When the bit being processed is the last one (cnt == WIDTH-1), the same edge does the following:
    - loads Diff with the final shifted value;
    - sets Bout = brw';
    - sets Overflow = (A_l[MSB] != B_l[MSB]) & (Diff[MSB] != A_l[MSB]), using the latched operands;
    - goes to DONE.
- DONE:
  - Done = 1 for exactly this cycle.
  - Next edge returns to IDLE.
  - Start asserted in DONE is ignored.
- Latency: if Start is accepted at edge 0, Diff, Bout and Overflow update at edge WIDTH, and Done is high during the cycle that follows edge WIDTH. A new Start can be accepted no earlier than edge WIDTH+2.
- Busy: high exactly in SHIFT, i.e. WIDTH cycles per operation.
- Start while Busy or in DONE: ignored; it is not queued.
- Input stability: A, B and Bin may change freely after the accepted edge, because they are latched.
- Output stability: Diff, Bout and Overflow hold the previous result throughout a new operation and change only at the completion edge.
- Reset mid-operation: aborts immediately to the reset values, with no Done pulse. The previous result is cleared.
- Arithmetic: modulo 2^WIDTH. Bout is the unsigned borrow. Overflow is evaluated including the effect of Bin.

Decomposition:
- Shared package / header:
  - state encodings ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2 (value 3 is illegal and recovers to IDLE);
  - the default WIDTH constant.
- One sub-module: FullSubtractor, a 1-bit combinational cell.
  - Inputs: In1, In2, Bin.
  - Outputs: Diff, Bout.
  - Instantiated once in the SHIFT datapath and unit-tested standalone with an exhaustive 8-row sweep.

Test Plan:
- Basic subtract: WIDTH=8, A=0x05, B=0x03, Bin=0, Start pulse → Busy high for 8 cycles, Done pulse 8 cycles after the Start edge, Diff=0x02, Bout=0, Overflow=0.
- Wrap-around: A=0x03, B=0x05, Bin=0 → Diff=0xFE, Bout=1, Overflow=0. Also A=0x00, B=0x00, Bin=1 → Diff=0xFF, Bout=1.
- Signed overflow: A=0x80, B=0x01 → Diff=0x7F, Bout=0, Overflow=1. Also A=0x7F, B=0xFF → Diff=0x80, Bout=1, Overflow=1.
- Handshake:
  - Start held high continuously → an operation completes every WIDTH+2 cycles; Start pulses during Busy or DONE cause no extra Done pulses.
  - Operands changed mid-operation → the result uses the latched values.
- Reset mid-operation: Rst=1 at cycle 4 of a SHIFT → next cycle all outputs are 0 and the state is IDLE, no Done pulse; a subsequent 0x10-0x01 gives 0x0F.
- Exhaustive check: WIDTH=4, all 512 {A,B,Bin} combinations, with each result compared against (A-B-Bin) mod 16 and the expected borrow and overflow; the bench fails on any mismatch.
